// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcode/funct constants, the decoded-lane record and
// the decode buffer state encoding.
package decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     imm;
        logic            illegal;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
    } instruction_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        SKID  = 2'd2
    } decode_state_e;

endpackage

// File: rtl/rv32i_lane_decode.sv
// Purely combinational single-lane RV32I decoder: fields, sign-extended immediate,
// operand-usage flags and illegal-encoding detection.
module rv32i_lane_decode
    import decode_stage_pkg::*;
(
    input  logic [XLEN-1:0] addr,
    input  logic [31:0]     instr,
    output instruction_t    inst
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_z;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd_f   = instr[11:7];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z = {20'h00000, instr[31:20]};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch.
        inst        = '0;
        inst.addr   = addr;
        inst.opcode = opcode;
        inst.illegal = (instr[1:0] != 2'b11);

        unique case (opcode)
            OPC_LOAD: begin
                inst.funct3 = f3; inst.rd = rd_f; inst.rs1 = rs1_f; inst.imm = imm_i;
                inst.uses_rs1 = 1'b1; inst.writes_rd = 1'b1;
                if (f3 inside {3'd3, 3'd6, 3'd7}) inst.illegal = 1'b1;
            end
            OPC_STORE: begin
                inst.funct3 = f3; inst.rs1 = rs1_f; inst.rs2 = rs2_f; inst.imm = imm_s;
                inst.uses_rs1 = 1'b1; inst.uses_rs2 = 1'b1;
                if (f3 > 3'd2) inst.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                inst.funct3 = f3; inst.rd = rd_f; inst.rs1 = rs1_f; inst.imm = imm_i;
                inst.uses_rs1 = 1'b1; inst.writes_rd = 1'b1;
                // Shift-immediates carry their type in funct7; keep it for execute.
                if (f3 == F3_SLL || f3 == F3_SRL_SRA) inst.funct7 = f7;
                if (f3 == F3_SLL && f7 != F7_BASE) inst.illegal = 1'b1;
                if (f3 == F3_SRL_SRA && !(f7 inside {F7_BASE, F7_ALT})) inst.illegal = 1'b1;
            end
            OPC_OP: begin
                inst.funct3 = f3; inst.funct7 = f7;
                inst.rd = rd_f; inst.rs1 = rs1_f; inst.rs2 = rs2_f;
                inst.uses_rs1 = 1'b1; inst.uses_rs2 = 1'b1; inst.writes_rd = 1'b1;
                if (!(f7 == F7_BASE || (f7 == F7_ALT && f3 inside {F3_ADD_SUB, F3_SRL_SRA})))
                    inst.illegal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                inst.rd = rd_f; inst.imm = imm_u; inst.writes_rd = 1'b1;
            end
            OPC_JAL: begin
                inst.rd = rd_f; inst.imm = imm_j; inst.writes_rd = 1'b1;
            end
            OPC_JALR: begin
                inst.funct3 = f3; inst.rd = rd_f; inst.rs1 = rs1_f; inst.imm = imm_i;
                inst.uses_rs1 = 1'b1; inst.writes_rd = 1'b1;
                if (f3 != 3'd0) inst.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                inst.funct3 = f3; inst.rs1 = rs1_f; inst.rs2 = rs2_f; inst.imm = imm_b;
                inst.uses_rs1 = 1'b1; inst.uses_rs2 = 1'b1;
                if (f3 inside {3'd2, 3'd3}) inst.illegal = 1'b1;
            end
            OPC_MISC_MEM: begin
                inst.funct3 = f3; inst.imm = imm_z;
            end
            OPC_SYSTEM: begin
                // CSR immediate forms reuse the rs1 field as a 5-bit uimm.
                inst.funct3 = f3; inst.imm = imm_z; inst.rd = rd_f; inst.rs1 = rs1_f;
                inst.uses_rs1  = (f3 != 3'd0) && !f3[2];
                inst.writes_rd = (f3 != 3'd0);
            end
            default: inst.illegal = 1'b1;
        endcase

        if (inst.rd == 5'd0) inst.writes_rd = 1'b0;

        if (inst.illegal) begin
            inst         = '0;
            inst.addr    = addr;
            inst.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// WIDTH-lane registered RV32I decode stage with a main register plus skid entry,
// so fetch sees a registered ready and rename back-pressure never reaches it combinationally.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        if_valid,
    output logic                        if_ready,
    input  logic [WIDTH-1:0]            if_lane_valid,
    input  logic [WIDTH*ADDR_WIDTH-1:0] if_addr,
    input  logic [WIDTH*DATA_WIDTH-1:0] if_instr,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [WIDTH-1:0]            id_lane_valid,
    output instruction_t [WIDTH-1:0]    id_inst,
    output logic [CNT_WIDTH-1:0]        decode_count
);

    typedef struct packed {
        logic [WIDTH-1:0]         lane_valid;
        instruction_t [WIDTH-1:0] inst;
    } bundle_t;

    decode_state_e          state_q, state_d;
    bundle_t                main_q, main_d;
    bundle_t                skid_q, skid_d;
    bundle_t                in_bundle;
    logic                   if_ready_q, if_ready_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   lanes_out;
    logic [CNT_WIDTH:0]     count_sum;
    logic                   in_xfer, out_xfer, in_keep;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        logic [XLEN-1:0] lane_addr;
        assign lane_addr = XLEN'(if_addr[g*ADDR_WIDTH +: ADDR_WIDTH]);

        rv32i_lane_decode u_dec (
            .addr  (lane_addr),
            .instr (if_instr[g*DATA_WIDTH +: 32]),
            .inst  (in_bundle.inst[g])
        );
    end

    assign in_bundle.lane_valid = if_lane_valid;

    assign in_xfer  = if_valid && if_ready_q;
    assign out_xfer = (state_q != EMPTY) && id_ready;
    // Empty bundles are consumed but never occupy a buffer slot; flush drops the input.
    assign in_keep  = in_xfer && (|if_lane_valid) && !flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_keep) begin
                        main_d  = in_bundle;
                        state_d = MAIN;
                    end
                end
                MAIN: begin
                    unique case ({in_keep, out_xfer})
                        2'b10: begin
                            skid_d  = in_bundle;
                            state_d = SKID;
                        end
                        2'b01: state_d = EMPTY;
                        2'b11: main_d  = in_bundle;
                        default: ;
                    endcase
                end
                SKID: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = MAIN;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        if_ready_d = (state_d != SKID);
    end

    always_comb begin
        lanes_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lanes_out = lanes_out + CNT_WIDTH'(main_q.lane_valid[i]);
        end
        count_sum = {1'b0, count_q} + {1'b0, lanes_out};
        count_d   = count_q;
        if (out_xfer && !flush) begin
            count_d = count_sum[CNT_WIDTH] ? '1 : count_sum[CNT_WIDTH-1:0];
        end
    end

    // NOTE: the bundle registers are reset too, since id_inst must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            if_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            if_ready_q <= if_ready_d;
            count_q    <= count_d;
        end
    end

    assign if_ready      = if_ready_q;
    assign id_valid      = (state_q != EMPTY);
    assign id_lane_valid = id_valid ? main_q.lane_valid : '0;
    assign id_inst       = main_q.inst;
    assign decode_count  = count_q;

    a_lane_prefix: assert property (@(posedge clk) disable iff (!rst_n)
        in_xfer |-> ((if_lane_valid & (if_lane_valid + WIDTH'(1))) == '0));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (id_valid && !id_ready && !flush) |=>
            (id_valid && $stable(id_lane_valid) && $stable(id_inst)));

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (WIDTH=2): decode fields, back-pressure ordering,
// illegal lanes, flush and asynchronous reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int WIDTH = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   if_valid = 1'b0;
    logic                   if_ready;
    logic [WIDTH-1:0]       if_lane_valid = '0;
    logic [WIDTH*32-1:0]    if_addr = '0;
    logic [WIDTH*32-1:0]    if_instr = '0;
    logic                   id_valid;
    logic                   id_ready = 1'b0;
    logic [WIDTH-1:0]       id_lane_valid;
    instruction_t [WIDTH-1:0] id_inst;
    logic [31:0]            decode_count;

    int total = 0;
    int bad   = 0;

    decode_stage #(.WIDTH(WIDTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_lane_valid (if_lane_valid),
        .if_addr       (if_addr),
        .if_instr      (if_instr),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_lane_valid (id_lane_valid),
        .id_inst       (id_inst),
        .decode_count  (decode_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] lv, input logic [31:0] a0, input logic [31:0] i0,
                         input logic [31:0] a1, input logic [31:0] i1);
        if_valid      = 1'b1;
        if_lane_valid = lv;
        if_addr       = {a1, a0};
        if_instr      = {i1, i0};
    endtask

    task automatic idle_input();
        if_valid      = 1'b0;
        if_lane_valid = '0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst id_valid", 32'(id_valid), 32'd0);
        check("rst if_ready", 32'(if_ready), 32'd1);
        check("rst count", decode_count, 32'd0);
        check("rst lane_valid", 32'(id_lane_valid), 32'd0);
        check("rst inst0 addr", id_inst[0].addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // addi / lw pair
        id_ready = 1'b1;
        offer(2'b11, 32'h100, 32'h00500093, 32'h104, 32'hFFC12083);
        tick();
        idle_input();
        check("t2 id_valid", 32'(id_valid), 32'd1);
        check("t2 lane_valid", 32'(id_lane_valid), 32'd3);
        check("t2 l0 addr", id_inst[0].addr, 32'h100);
        check("t2 l0 opcode", 32'(id_inst[0].opcode), 32'h13);
        check("t2 l0 rd", 32'(id_inst[0].rd), 32'd1);
        check("t2 l0 rs1", 32'(id_inst[0].rs1), 32'd0);
        check("t2 l0 imm", id_inst[0].imm, 32'd5);
        check("t2 l0 wr_rd", 32'(id_inst[0].writes_rd), 32'd1);
        check("t2 l1 addr", id_inst[1].addr, 32'h104);
        check("t2 l1 opcode", 32'(id_inst[1].opcode), 32'h03);
        check("t2 l1 rd", 32'(id_inst[1].rd), 32'd1);
        check("t2 l1 rs1", 32'(id_inst[1].rs1), 32'd2);
        check("t2 l1 funct3", 32'(id_inst[1].funct3), 32'd2);
        check("t2 l1 imm", id_inst[1].imm, 32'hFFFFFFFC);
        check("t2 l1 uses_rs2", 32'(id_inst[1].uses_rs2), 32'd0);
        tick();
        check("t2 drained", 32'(id_valid), 32'd0);
        check("t2 count", decode_count, 32'd2);

        // Back-pressure: A (1 lane), B, C offered while rename stalls
        id_ready = 1'b0;
        offer(2'b01, 32'h200, 32'h00100113, 32'h204, 32'h00000013);
        tick();
        check("t3 A valid", 32'(id_valid), 32'd1);
        check("t3 A lane_valid", 32'(id_lane_valid), 32'd1);
        check("t3 ready after A", 32'(if_ready), 32'd1);
        offer(2'b11, 32'h210, 32'h00000013, 32'h214, 32'h00000013);
        tick();
        check("t3 ready after B", 32'(if_ready), 32'd0);
        check("t3 A held addr", id_inst[0].addr, 32'h200);
        offer(2'b11, 32'h220, 32'h00000013, 32'h224, 32'h00000013);
        tick();
        check("t3 C blocked", 32'(if_ready), 32'd0);
        check("t3 A stable addr", id_inst[0].addr, 32'h200);
        check("t3 A stable imm", id_inst[0].imm, 32'd1);
        id_ready = 1'b1;
        tick();
        check("t3 B out addr0", id_inst[0].addr, 32'h210);
        check("t3 B out addr1", id_inst[1].addr, 32'h214);
        check("t3 B lane_valid", 32'(id_lane_valid), 32'd3);
        check("t3 ready reopened", 32'(if_ready), 32'd1);
        tick();
        idle_input();
        check("t3 C out addr0", id_inst[0].addr, 32'h220);
        check("t3 C out addr1", id_inst[1].addr, 32'h224);
        tick();
        check("t3 drained", 32'(id_valid), 32'd0);
        check("t3 count", decode_count, 32'd7);

        // Immediates: beq / jal, then lui alone in lane 0
        offer(2'b11, 32'h300, 32'hFE000EE3, 32'h304, 32'h800000EF);
        tick();
        check("t4 beq imm", id_inst[0].imm, 32'hFFFFFFFC);
        check("t4 beq rd", 32'(id_inst[0].rd), 32'd0);
        check("t4 beq uses_rs2", 32'(id_inst[0].uses_rs2), 32'd1);
        check("t4 beq wr_rd", 32'(id_inst[0].writes_rd), 32'd0);
        check("t4 jal imm", id_inst[1].imm, 32'hFFF00000);
        check("t4 jal rd", 32'(id_inst[1].rd), 32'd1);
        check("t4 jal uses_rs1", 32'(id_inst[1].uses_rs1), 32'd0);
        offer(2'b01, 32'h308, 32'h123450B7, 32'h30C, 32'h00000000);
        tick();
        idle_input();
        check("t4 lui imm", id_inst[0].imm, 32'h12345000);
        check("t4 lui rd", 32'(id_inst[0].rd), 32'd1);
        check("t4 lui lane_valid", 32'(id_lane_valid), 32'd1);
        tick();

        // Illegal encodings
        offer(2'b11, 32'h400, 32'h00000000, 32'h404, 32'h40001033);
        tick();
        check("t5 zero illegal", 32'(id_inst[0].illegal), 32'd1);
        check("t5 zero addr", id_inst[0].addr, 32'h400);
        check("t5 zero opcode", 32'(id_inst[0].opcode), 32'd0);
        check("t5 op illegal", 32'(id_inst[1].illegal), 32'd1);
        check("t5 op addr", id_inst[1].addr, 32'h404);
        check("t5 op rd", 32'(id_inst[1].rd), 32'd0);
        check("t5 op funct7", 32'(id_inst[1].funct7), 32'd0);
        check("t5 lane_valid", 32'(id_lane_valid), 32'd3);
        offer(2'b01, 32'h408, 32'h00003003, 32'h40C, 32'h00000013);
        tick();
        idle_input();
        check("t5 ld illegal", 32'(id_inst[0].illegal), 32'd1);
        check("t5 ld addr", id_inst[0].addr, 32'h408);
        check("t5 ld imm", id_inst[0].imm, 32'd0);
        check("t5 ld rs1", 32'(id_inst[0].rs1), 32'd0);
        tick();
        check("t5 count", decode_count, 32'd13);

        // Flush while in SKID with a bundle offered
        id_ready = 1'b0;
        offer(2'b11, 32'h500, 32'h00000013, 32'h504, 32'h00000013);
        tick();
        offer(2'b11, 32'h510, 32'h00000013, 32'h514, 32'h00000013);
        tick();
        check("t6 in skid", 32'(if_ready), 32'd0);
        offer(2'b11, 32'h520, 32'h00000013, 32'h524, 32'h00000013);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_input();
        check("t6 flush id_valid", 32'(id_valid), 32'd0);
        check("t6 flush if_ready", 32'(if_ready), 32'd1);
        id_ready = 1'b1;
        tick();
        check("t6 nothing emerges", 32'(id_valid), 32'd0);
        check("t6 count kept", decode_count, 32'd13);

        // Flush with an input transfer while EMPTY drops it
        offer(2'b11, 32'h530, 32'h00000013, 32'h534, 32'h00000013);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_input();
        check("t6 dropped in", 32'(id_valid), 32'd0);

        // Bundle with no valid lanes is consumed without output
        offer(2'b00, 32'h540, 32'h00000013, 32'h544, 32'h00000013);
        tick();
        idle_input();
        check("empty bundle", 32'(id_valid), 32'd0);
        check("empty bundle ready", 32'(if_ready), 32'd1);
        check("empty bundle count", decode_count, 32'd13);

        // Asynchronous reset while in SKID
        id_ready = 1'b0;
        offer(2'b11, 32'h600, 32'h00000013, 32'h604, 32'h00000013);
        tick();
        offer(2'b11, 32'h610, 32'h00000013, 32'h614, 32'h00000013);
        tick();
        idle_input();
        check("t1 pre-reset skid", 32'(if_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1 reset id_valid", 32'(id_valid), 32'd0);
        check("t1 reset if_ready", 32'(if_ready), 32'd1);
        check("t1 reset count", decode_count, 32'd0);
        check("t1 reset lane_valid", 32'(id_lane_valid), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check("t1 post-reset idle", 32'(id_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
